// File: rtl/dsp_adder_arbiter_if.sv
// rtl/dsp_adder_arbiter_if.sv - request/response handshake bundle for the two adder requesters
interface dsp_adder_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [31:0] req0_a;
   logic [31:0] req0_b;
   logic        req1_valid;
   logic        req1_ready;
   logic [31:0] req1_a;
   logic [31:0] req1_b;
   logic        resp0_valid;
   logic        resp0_ready;
   logic [31:0] resp0_sum;
   logic        resp1_valid;
   logic        resp1_ready;
   logic [31:0] resp1_sum;

   modport master (
      output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
      output resp0_ready, resp1_ready,
      input  req0_ready, req1_ready,
      input  resp0_valid, resp0_sum, resp1_valid, resp1_sum
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
      input  resp0_ready, resp1_ready,
      output req0_ready, req1_ready,
      output resp0_valid, resp0_sum, resp1_valid, resp1_sum
   );
endinterface

// File: rtl/dsp_adder_arbiter.sv
// rtl/dsp_adder_arbiter.sv - round-robin sharing of one pipelined DSP adder between two requesters
module dsp_adder_arbiter #(
   parameter int LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   dsp_adder_arbiter_if.slave    bus,
   output logic [31:0]           adder_in1,
   output logic [31:0]           adder_in2,
   input  logic [31:0]           adder_out,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   localparam logic [2:0] LAT = 3'(LATENCY);

   state_t      state;
   state_t      state_nx;
   logic [2:0]  cnt;
   logic        owner;
   logic        last_grant;
   logic        grant_valid;
   logic        grant;
   logic [31:0] sum0;
   logic [31:0] sum1;

   assign bus.resp0_valid = (state == DONE) && !owner;
   assign bus.resp1_valid = (state == DONE) && owner;
   assign bus.resp0_sum   = sum0;
   assign bus.resp1_sum   = sum1;

   always_comb begin
      state_nx       = state;
      grant_valid    = 1'b0;
      grant          = 1'b0;
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      case (state)
         IDLE: begin
            // on a tie the requester that did not win last time goes first
            if (bus.req0_valid && bus.req1_valid) begin
               grant_valid = 1'b1;
               grant       = ~last_grant;
            end else if (bus.req0_valid) begin
               grant_valid = 1'b1;
               grant       = 1'b0;
            end else if (bus.req1_valid) begin
               grant_valid = 1'b1;
               grant       = 1'b1;
            end
            if (grant_valid) begin
               state_nx       = WAIT;
               bus.req0_ready = !grant;
               bus.req1_ready = grant;
            end
         end
         WAIT: begin
            if (cnt == LAT) state_nx = DONE;
         end
         DONE: begin
            if (owner ? bus.resp1_ready : bus.resp0_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= 3'd0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         adder_in1  <= 32'd0;
         adder_in2  <= 32'd0;
         sum0       <= 32'd0;
         sum1       <= 32'd0;
         busy       <= 1'b0;
      end else begin
         state <= state_nx;
         busy  <= (state_nx != IDLE);
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  adder_in1  <= grant ? bus.req1_a : bus.req0_a;
                  adder_in2  <= grant ? bus.req1_b : bus.req0_b;
                  owner      <= grant;
                  last_grant <= grant;
                  cnt        <= 3'd0;
               end
            end
            WAIT: begin
               cnt <= cnt + 3'd1;
               // operands have been stable for LATENCY edges, so adder_out now matches them
               if (cnt == LAT) begin
                  if (owner) sum1 <= adder_out;
                  else       sum0 <= adder_out;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/dsp_adder_arbiter.md
Name: dsp_adder_arbiter

Overview:
Shares one DSP-block 32-bit adder between two requesters, e.g. the ALU and the branch-target/PC adder path.
- Accepts add requests over valid/ready handshakes and grants them round-robin.
- Drives the shared adder's operand inputs, waits the adder's fixed pipeline latency, then returns the sum to the granted requester over a valid/ready response handshake.
- Holds one outstanding operation at a time; sits between the requesters and the dsp_adder instance.

Parameters:
LATENCY, 1, clock edges from a change on adder_in1/adder_in2 to the matching value on adder_out (0 = combinational adder); legal range 0..7.

Ports:
clk  input  1  single system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
reqN_valid  input  1  (N = 0,1) requester N presents operands
reqN_ready  output  1  (N = 0,1) request accepted this cycle when valid & ready
reqN_a  input  32  (N = 0,1) operand A
reqN_b  input  32  (N = 0,1) operand B
respN_valid  output  1  (N = 0,1) sum available for requester N
respN_ready  input  1  (N = 0,1) requester N consumes the response
respN_sum  output  32  (N = 0,1) result, a + b mod 2^32
adder_in1  output  32  registered operand A to the shared adder
adder_in2  output  32  registered operand B to the shared adder
adder_out  input  32  shared adder result
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset is synchronous: when reset is high at a rising edge, all state is cleared.
  - FSM = IDLE, cnt = 0, last_grant = 1 (so requester 0 wins the first tie).
  - adder_in1 = adder_in2 = 0, resp0_sum = resp1_sum = 0, resp*_valid = 0, busy = 0.
- A reset asserted mid-operation discards the operation; no response is ever issued for it.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - reqN_ready is combinational and goes to at most one requester.
  - Only one requester valid: it gets ready.
  - Both valid: the requester != last_grant gets ready (round-robin).
  - No requester valid: both ready = 0.
  - Acceptance edge: the granted operands load into adder_in1/adder_in2, owner <= grant, last_grant <= grant, cnt <= 0, state -> WAIT.
- WAIT:
  - reqN_ready = 0. adder_in1/adder_in2 are held stable.
  - cnt increments each cycle.
  - In the cycle where cnt == LATENCY, adder_out is sampled into resp<owner>_sum, state -> DONE.
  - WAIT therefore lasts LATENCY+1 cycles.
- DONE:
  - resp<owner>_valid = 1, the other resp_valid = 0, reqN_ready = 0.
  - The response holds, with resp_sum stable, until resp<owner>_ready is high at an edge; then state -> IDLE.
  - respN_sum keeps its last value after the handshake; it is only updated on capture.
- Latency: request accepted at the end of cycle T -> resp_valid high from cycle T+LATENCY+2. With LATENCY=1 that is T+3.
- Throughput: with resp_ready tied high, the next request can be accepted in cycle T+LATENCY+3, i.e. one operation per LATENCY+3 cycles.
- Back-pressure: resp_ready low keeps the FSM in DONE indefinitely. No new grants are made, and the other requester's valid is ignored but not lost; it stays pending.
- Arithmetic: unsigned 32-bit wrap-around, no carry-out. The block never computes the sum itself; it must use adder_out.
- A request whose valid drops before acceptance is never serviced. reqN_a/reqN_b are sampled only at the acceptance edge.
- Non-granted requester: its valid may stay high across cycles, and it is granted at the next IDLE cycle.
- busy = (state != IDLE), registered.

Test Plan:
- Single op, LATENCY=1: req0 a=0x0000_0005, b=0x0000_0007, accepted in cycle 2 -> adder_in1/2 = 5/7 in cycle 3, resp0_valid in cycle 5 with resp0_sum=0x0000_000C; resp1_valid stays 0.
- Wrap-around: req1 a=0xFFFF_FFFF, b=0x0000_0002 -> resp1_sum=0x0000_0001, no other side effects.
- Fairness: both requesters valid continuously from reset, resp_ready high -> grants in the order 0,1,0,1. Each resp_sum matches its own operands, e.g. req0 1+1=2, req1 3+4=7.
- Back-pressure: resp0_ready held low 10 cycles with req1 valid -> resp0_valid and resp0_sum stay stable, req1_ready stays 0. After resp0_ready=1 -> IDLE next cycle, then req1 is granted.
- Reset mid-op: reset for 1 cycle while in WAIT -> next cycle IDLE, adder_in1/2 = 0, no resp_valid. A new req0 2+3 afterwards -> resp0_sum=5.
- LATENCY=3 build: accept at T -> resp_valid first high at T+5. A model adder with 3-stage delay yields the correct sum; an early sample is flagged by a scoreboard mismatch.
